// File: rtl/factorial_sequencer.sv
// rtl/factorial_sequencer.sv - iterative n! mod 64 engine with sticky overflow, one 6x6 multiply per clock.
// Optional FACT_EARLY_EXIT_EN: finish as soon as the accumulated product becomes 0.

module sixbitmul (
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic [5:0] p,
  output logic       ovf
);
  logic [11:0] full;

  assign full = a * b;
  assign p    = full[5:0];
  assign ovf  = |full[11:6];
endmodule

module factorial_sequencer #(
  parameter int NMAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] ain,
  output logic       busy,
  output logic       done,
  output logic [5:0] out,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  localparam logic [5:0] NMAX_V = 6'(NMAX);

  state_t     state_q, state_d;
  logic [5:0] acc_q, acc_d;
  logic [5:0] k_q, k_d;
  logic [5:0] n_q, n_d;
  logic       ovf_r_q, ovf_r_d;
  logic [5:0] out_q, out_d;
  logic       overflow_q, overflow_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  logic [5:0] mul_p;
  logic       mul_ovf;
  logic       last_step;

  sixbitmul u_mul (
    .a   (acc_q),
    .b   (k_q),
    .p   (mul_p),
    .ovf (mul_ovf)
  );

`ifdef FACT_EARLY_EXIT_EN
  // Once the product is 0 every later product stays 0 and overflow is already set.
  assign last_step = (k_q == n_q) || (mul_p == 6'd0);
`else
  assign last_step = (k_q == n_q);
`endif

  // Outputs are loaded on the edge that enters FIN so done and out rise together.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    k_d        = k_q;
    n_d        = n_q;
    ovf_r_d    = ovf_r_q;
    out_d      = out_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = ain;
          acc_d   = 6'd1;
          k_d     = 6'd1;
          ovf_r_d = 1'b0;
          if (ain == 6'd0 || ain > NMAX_V) begin
            state_d    = FIN;
            done_d     = 1'b1;
            out_d      = (ain == 6'd0) ? 6'd1 : 6'd0;
            overflow_d = (ain != 6'd0);
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        acc_d   = mul_p;
        ovf_r_d = ovf_r_q | mul_ovf;
        if (last_step) begin
          state_d    = FIN;
          done_d     = 1'b1;
          out_d      = mul_p;
          overflow_d = ovf_r_q | mul_ovf;
        end else begin
          k_d = k_q + 6'd1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= 6'd1;
      k_q        <= 6'd0;
      n_q        <= 6'd0;
      ovf_r_q    <= 1'b0;
      out_q      <= 6'd0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      n_q        <= n_d;
      ovf_r_q    <= ovf_r_d;
      out_q      <= out_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out      = out_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_factorial_sequencer.sv
// tb/tb_factorial_sequencer.sv - directed self-checking bench for factorial_sequencer.
// Honours FACT_EARLY_EXIT_EN for the expected latency of large operands.

module tb_factorial_sequencer;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] ain;
  logic       busy;
  logic       done;
  logic [5:0] out;
  logic       overflow;

  int checks;
  int fails;

  factorial_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ain      (ain),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Issues one start from IDLE and measures the cycle in which done appears (accept cycle + 1 = T+1).
  task automatic do_op(input string tag, input logic [5:0] a, input logic [5:0] exp_out,
                       input logic exp_ovf, input int exp_lat);
    int cyc;
    ain   = a;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_out"}, out, exp_out);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_busy"}, busy, 1);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int lat15;
    int ndone;
    int first_cyc;
    int dcyc[4];
    logic [5:0] first_out;

    checks = 0;
    fails  = 0;
    start  = 1'b0;
    ain    = 6'd0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("n0", 6'd0, 6'd1, 1'b0, 1);
    do_op("n1", 6'd1, 6'd1, 1'b0, 2);
    do_op("n3", 6'd3, 6'd6, 1'b0, 4);
    do_op("n4", 6'd4, 6'd24, 1'b0, 5);
    do_op("n5", 6'd5, 6'd56, 1'b1, 6);
    do_op("n6", 6'd6, 6'd16, 1'b1, 7);
    do_op("n8", 6'd8, 6'd0, 1'b1, 9);
`ifdef FACT_EARLY_EXIT_EN
    lat15 = 9;
`else
    lat15 = 16;
`endif
    do_op("n15", 6'd15, 6'd0, 1'b1, lat15);
    do_op("n16", 6'd16, 6'd0, 1'b1, 1);
    do_op("n63", 6'd63, 6'd0, 1'b1, 1);

    // Start pulse while busy must be ignored.
    ain   = 6'd4;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ain   = 6'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    first_cyc = 0;
    first_out = 6'd0;
    for (int c = 4; c < 24; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          first_cyc = c;
          first_out = out;
        end
      end
      @(posedge clk);
      #1;
    end
    chk("hs_ndone", ndone, 1);
    chk("hs_out", first_out, 24);
    chk("hs_lat", first_cyc, 5);

    do_op("hold_n3", 6'd3, 6'd6, 1'b0, 4);
    repeat (20) @(posedge clk);
    #1;
    chk("hold_out", out, 6);
    chk("hold_ovf", overflow, 0);
    chk("hold_busy", busy, 0);

    // Continuous start: n=3 should complete every 5 cycles.
    ain   = 6'd3;
    start = 1'b1;
    ndone = 0;
    dcyc  = '{default: 0};
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && ndone < 4) begin
        dcyc[ndone] = c;
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b_count", (ndone >= 3), 1);
    chk("b2b_first", dcyc[0], 4);
    chk("b2b_gap1", dcyc[1] - dcyc[0], 5);
    chk("b2b_gap2", dcyc[2] - dcyc[1], 5);
    repeat (10) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of n=10.
    ain   = 6'd10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    chk("mid_rst_nodone", ndone, 0);
    chk("mid_rst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
